// File: rtl/auto_pilot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | auto_pkg : shared encodings for the auto_pilot wall follower         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package auto_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_DECIDE = 3'd2;
  localparam logic [2:0] ST_TURN_R = 3'd3;
  localparam logic [2:0] ST_TURN_L = 3'd4;
  localparam logic [2:0] ST_UTURN  = 3'd5;
  localparam logic [2:0] ST_LEAVE  = 3'd6;
  localparam logic [2:0] ST_CRUISE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_DECIDE = ST_DECIDE,
    S_TURN_R = ST_TURN_R,
    S_TURN_L = ST_TURN_L,
    S_UTURN  = ST_UTURN,
    S_LEAVE  = ST_LEAVE,
    S_CRUISE = ST_CRUISE
  } state_t;

  localparam logic [1:0] NS_OFF  = 2'b00;
  localparam logic [1:0] NS_IDLE = 2'b01;
  localparam logic [1:0] NS_MOVE = 2'b10;
  localparam logic [1:0] NS_TURN = 2'b11;

  localparam logic [3:0] MV_NONE  = 4'b0000;
  localparam logic [3:0] MV_FWD   = 4'b0001;
  localparam logic [3:0] MV_BWD   = 4'b0010;
  localparam logic [3:0] MV_LEFT  = 4'b0100;
  localparam logic [3:0] MV_RIGHT = 4'b1000;

  // detector bit positions: {back, front, right, left}
  localparam int DET_LEFT  = 0;
  localparam int DET_RIGHT = 1;
  localparam int DET_FRONT = 2;

  // number of open sides among {front, right, left}
  function automatic logic [1:0] open_count(input logic [2:0] frl);
    return {1'b0, ~frl[2]} + {1'b0, ~frl[1]} + {1'b0, ~frl[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/auto_pilot_det_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | det_filter : detector synchronizer and stability qualifier           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module det_filter #(
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] detector,
  output logic [3:0] det_q,
  output logic       stable
);

  localparam logic [31:0] c_stable_last = 32'(STABLE_CYCLES - 1);

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_ref;
  logic [31:0] r_cnt;

  // r_cnt counts cycles r_sync2 has matched r_ref, starting at 1 on a change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
      r_ref   <= 4'b0000;
      r_cnt   <= 32'd0;
      det_q   <= 4'b0000;
      stable  <= 1'b0;
    end else begin
      r_sync1 <= detector;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_ref) begin
        r_ref  <= r_sync2;
        r_cnt  <= 32'd1;
        stable <= 1'b0;
      end else if (!stable) begin
        if (r_cnt >= c_stable_last) begin
          stable <= 1'b1;
          det_q  <= r_ref;
        end else begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/auto_pilot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | auto_pilot : right-hand wall follower with beacon budget             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module auto_pilot
  import auto_pkg::*;
#(
  parameter int TURN_CYCLES   = 90_000_000,
  parameter int LEAVE_CYCLES  = 50_000_000,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int MAX_BEACONS   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic [1:0] global_state,
  input  logic [3:0] detector,
  output logic [1:0] next_state,
  output logic [3:0] next_moving_state,
  output logic       place_beacon,
  output logic       destroy_beacon,
  output logic [3:0] beacon_count
);

  localparam logic [31:0] c_turn_last   = 32'(TURN_CYCLES - 1);
  localparam logic [31:0] c_uturn_last  = 32'(2 * TURN_CYCLES - 1);
  localparam logic [31:0] c_leave_last  = 32'(LEAVE_CYCLES - 1);
  localparam logic [3:0]  c_max_beacons = 4'(MAX_BEACONS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_timer;
  logic [31:0] w_timer_nxt;
  logic [1:0]  w_ns_nxt;
  logic [3:0]  w_mv_nxt;
  logic [3:0]  w_count_nxt;
  logic        w_place_nxt;
  logic        w_destroy_nxt;
  logic        w_en;
  logic [3:0]  w_det_q;
  logic        w_stable;
  logic [1:0]  w_open_cnt;
  logic        w_unused_back;

  det_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_det_filter (
    .clk     (clk),
    .rst     (rst),
    .detector(detector),
    .det_q   (w_det_q),
    .stable  (w_stable)
  );

  assign w_en          = power & (global_state == 2'b11);
  assign w_open_cnt    = open_count(w_det_q[2:0]);
  assign w_unused_back = w_det_q[3];

  always_comb begin
    w_state_nxt   = r_state;
    w_place_nxt   = 1'b0;
    w_destroy_nxt = 1'b0;
    w_count_nxt   = beacon_count;

    case (r_state)
      S_IDLE:   if (w_en) w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_stable) w_state_nxt = S_DECIDE;
      S_DECIDE: begin
        if (!w_det_q[DET_RIGHT])      w_state_nxt = S_TURN_R;
        else if (!w_det_q[DET_FRONT]) w_state_nxt = S_LEAVE;
        else if (!w_det_q[DET_LEFT])  w_state_nxt = S_TURN_L;
        else                          w_state_nxt = S_UTURN;
        // open_cnt >= 2 and == 0 are disjoint, so at most one pulse fires
        if (w_open_cnt >= 2'd2 && beacon_count < c_max_beacons) begin
          w_place_nxt = 1'b1;
          w_count_nxt = beacon_count + 4'd1;
        end else if (w_open_cnt == 2'd0 && beacon_count != 4'd0) begin
          w_destroy_nxt = 1'b1;
          w_count_nxt   = beacon_count - 4'd1;
        end
      end
      S_TURN_R: if (r_timer == c_turn_last)  w_state_nxt = S_LEAVE;
      S_TURN_L: if (r_timer == c_turn_last)  w_state_nxt = S_LEAVE;
      S_UTURN:  if (r_timer == c_uturn_last) w_state_nxt = S_LEAVE;
      S_LEAVE:  if (r_timer == c_leave_last) w_state_nxt = S_CRUISE;
      S_CRUISE: begin
        if (w_stable && (w_det_q[DET_FRONT] || !w_det_q[DET_LEFT] || !w_det_q[DET_RIGHT]))
          w_state_nxt = S_SETTLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase

    if (!w_en) begin
      w_state_nxt   = S_IDLE;
      w_place_nxt   = 1'b0;
      w_destroy_nxt = 1'b0;
      w_count_nxt   = beacon_count;
    end

    w_timer_nxt = (w_state_nxt != r_state) ? 32'd0 : r_timer + 32'd1;

    // Moore outputs of the state being entered
    w_ns_nxt = NS_IDLE;
    w_mv_nxt = MV_NONE;
    case (w_state_nxt)
      S_IDLE:   w_ns_nxt = power ? NS_IDLE : NS_OFF;
      S_TURN_R: begin w_ns_nxt = NS_TURN; w_mv_nxt = MV_RIGHT; end
      S_TURN_L: begin w_ns_nxt = NS_TURN; w_mv_nxt = MV_LEFT;  end
      S_UTURN:  begin w_ns_nxt = NS_TURN; w_mv_nxt = MV_RIGHT; end
      S_LEAVE,
      S_CRUISE: begin w_ns_nxt = NS_MOVE; w_mv_nxt = MV_FWD;   end
      default:  begin w_ns_nxt = NS_IDLE; w_mv_nxt = MV_NONE;  end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_timer           <= 32'd0;
      beacon_count      <= 4'd0;
      next_state        <= power ? NS_IDLE : NS_OFF;
      next_moving_state <= MV_NONE;
      place_beacon      <= 1'b0;
      destroy_beacon    <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_timer           <= w_timer_nxt;
      beacon_count      <= w_count_nxt;
      next_state        <= w_ns_nxt;
      next_moving_state <= w_mv_nxt;
      place_beacon      <= w_place_nxt;
      destroy_beacon    <= w_destroy_nxt;
    end
  end

endmodule
`default_nettype wire
